// File: rtl/music_sequencer_pkg.sv
// Shared state type, widths and note codes for the alarm music sequencer and its ROM.
package music_pkg;

    localparam int ADDR_W = 8;
    localparam int NOTE_W = 8;

    localparam logic [NOTE_W-1:0] NOTE_REST = 8'd0;
    localparam logic [NOTE_W-1:0] NOTE_A3   = 8'd18;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 8'd21;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 8'd23;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 8'd25;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 8'd26;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 8'd28;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 8'd30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_PAUSE,
        ST_SNOOZE
    } music_seq_state_t;

    // Long silences are note count * slot length; clamp instead of wrapping if that overflows 32 bits.
    function automatic logic [31:0] timer_product(input longint unsigned a, input longint unsigned b);
        longint unsigned p;
        p = a * b;
        return (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

endpackage

// File: rtl/music_sequencer_seq_timer.sv
// Loadable down-counter; expire is high on the last cycle of a loaded interval (count == 1).
module seq_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/music_sequencer.sv
// Alarm music sequencer: steps the note ROM at a fixed tempo with gaps, end pause and snooze.
// Optional build macro MUSIC_SEQ_REPEAT_LIMIT_EN stops the alarm after MAX_REPEATS plays.
module music_sequencer
    import music_pkg::*;
#(
    parameter int NOTE_CYCLES     = 16777216,
    parameter int GAP_CYCLES      = 1048576,
    parameter int END_PAUSE_NOTES = 8,
    parameter int SNOOZE_NOTES    = 1792,
    parameter int MAX_REPEATS     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              snooze,
    input  logic [NOTE_W-1:0] rom_note,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_en,
    output logic              playing,
    output logic              snoozing,
    output logic              song_done
);

    // FETCH and LOAD take one cycle each, so PLAY gets the rest of the slot not used by GAP.
    localparam logic [31:0] PLAY_LOAD   = 32'(NOTE_CYCLES - GAP_CYCLES - 2);
    localparam logic [31:0] GAP_LOAD    = 32'(GAP_CYCLES);
    localparam logic [31:0] PAUSE_LOAD  = timer_product(64'(END_PAUSE_NOTES), 64'(NOTE_CYCLES));
    localparam logic [31:0] SNOOZE_LOAD = timer_product(64'(SNOOZE_NOTES), 64'(NOTE_CYCLES));

    music_seq_state_t state, nxt;
    logic        tmr_load;
    logic [31:0] tmr_value;
    logic        tmr_expire;
    logic        limit_hit;
    logic        idle_or_snz;

    assign idle_or_snz = (state == ST_IDLE) || (state == ST_SNOOZE);

    seq_timer #(.W(32)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt       = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (stop) begin
            nxt      = ST_IDLE;
            tmr_load = 1'b1;
        end else if (snooze && !idle_or_snz) begin
            nxt       = ST_SNOOZE;
            tmr_load  = 1'b1;
            tmr_value = SNOOZE_LOAD;
        end else if (start && idle_or_snz) begin
            nxt      = ST_FETCH;
            tmr_load = 1'b1;
        end else begin
            case (state)
                ST_FETCH: nxt = ST_LOAD;
                ST_LOAD: begin
                    tmr_load = 1'b1;
                    if (rom_note != NOTE_REST) begin
                        nxt       = ST_PLAY;
                        tmr_value = PLAY_LOAD;
                    end else begin
                        nxt       = ST_PAUSE;
                        tmr_value = PAUSE_LOAD;
                    end
                end
                ST_PLAY: begin
                    if (tmr_expire) begin
                        nxt       = ST_GAP;
                        tmr_load  = 1'b1;
                        tmr_value = GAP_LOAD;
                    end
                end
                ST_GAP:    if (tmr_expire) nxt = ST_FETCH;
                ST_PAUSE:  if (tmr_expire) nxt = limit_hit ? ST_IDLE : ST_FETCH;
                ST_SNOOZE: if (tmr_expire) nxt = ST_FETCH;
                default:   nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        note_en   = (state == ST_PLAY);
        playing   = (state != ST_IDLE);
        snoozing  = (state == ST_SNOOZE);
        song_done = (state == ST_LOAD) && (rom_note == NOTE_REST) && (nxt == ST_PAUSE);
    end

    // Only GAP advances the address; every other way into FETCH restarts the song.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            note_out <= '0;
        end else if (nxt == ST_IDLE) begin
            rom_addr <= '0;
            note_out <= '0;
        end else if (nxt == ST_FETCH && state == ST_GAP) begin
            rom_addr <= rom_addr + ADDR_W'(1);
        end else if (nxt == ST_FETCH) begin
            rom_addr <= '0;
        end else if (state == ST_LOAD && (nxt == ST_PLAY || nxt == ST_PAUSE)) begin
            note_out <= rom_note;
        end
    end

`ifdef MUSIC_SEQ_REPEAT_LIMIT_EN
    logic [3:0] rep_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if ((nxt == ST_SNOOZE && state != ST_SNOOZE) || (nxt == ST_FETCH && idle_or_snz)) begin
            rep_cnt <= '0;
        end else if (song_done && rep_cnt != 4'hF) begin
            rep_cnt <= rep_cnt + 4'd1;
        end
    end

    assign limit_hit = (int'(rep_cnt) >= MAX_REPEATS);
`else
    logic [31:0] unused_max_repeats;
    assign unused_max_repeats = 32'(MAX_REPEATS);
    assign limit_hit          = 1'b0;
`endif

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer with a slot-level reference model of the song flow.
`timescale 1ns/1ps
module tb_music_sequencer;

    localparam int NC = 8;
    localparam int GC = 2;
    localparam int EP = 2;
    localparam int SN = 3;
    localparam int MR = 2;
`ifdef MUSIC_SEQ_REPEAT_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif
    localparam int M_IDLE = 0, M_SONG = 1, M_PAUSE = 2, M_SNZ = 3;

    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic [7:0] rom_note, rom_addr, note_out;
    logic       note_en, playing, snoozing, song_done;
    logic [7:0] rom_mem [256];
    logic [19:0] obs;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int m_mode, m_pos, m_addr, m_note, m_reps;

    music_sequencer #(
        .NOTE_CYCLES(NC), .GAP_CYCLES(GC), .END_PAUSE_NOTES(EP),
        .SNOOZE_NOTES(SN), .MAX_REPEATS(MR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .snooze(snooze),
        .rom_note(rom_note), .rom_addr(rom_addr), .note_out(note_out),
        .note_en(note_en), .playing(playing), .snoozing(snoozing), .song_done(song_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_note <= rom_mem[rom_addr];
    assign obs = {rom_addr, note_out, note_en, playing, snoozing, song_done};

    // Reference: a song is a sequence of NC-cycle slots; position 0 fetch, 1 load,
    // positions 2..NC-GC-1 audible, remainder silent.
    task automatic model_reset();
        m_mode = M_IDLE; m_pos = 0; m_addr = 0; m_note = 0; m_reps = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit sn);
        if (sp) begin
            m_mode = M_IDLE; m_pos = 0; m_addr = 0; m_note = 0;
        end else if (sn && (m_mode == M_SONG || m_mode == M_PAUSE)) begin
            m_mode = M_SNZ; m_pos = 0; m_reps = 0;
        end else if (st && (m_mode == M_IDLE || m_mode == M_SNZ)) begin
            m_mode = M_SONG; m_pos = 0; m_addr = 0; m_reps = 0;
        end else begin
            case (m_mode)
                M_SONG: begin
                    if (m_pos == 1 && rom_mem[m_addr] == 8'd0) begin
                        m_mode = M_PAUSE; m_pos = 0; m_note = 0; m_reps++;
                    end else if (m_pos == NC - 1) begin
                        m_pos = 0; m_addr = (m_addr + 1) % 256;
                    end else begin
                        if (m_pos == 1) m_note = rom_mem[m_addr];
                        m_pos++;
                    end
                end
                M_PAUSE: begin
                    if (m_pos == EP * NC - 1) begin
                        m_mode = (LIMIT && m_reps >= MR) ? M_IDLE : M_SONG;
                        m_pos = 0; m_addr = 0;
                    end else m_pos++;
                end
                M_SNZ: begin
                    if (m_pos == SN * NC - 1) begin
                        m_mode = M_SONG; m_pos = 0; m_addr = 0;
                    end else m_pos++;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [19:0] model_out();
        logic en, dn;
        en = (m_mode == M_SONG) && (m_pos >= 2) && (m_pos < NC - GC);
        dn = (m_mode == M_SONG) && (m_pos == 1) && (rom_mem[m_addr] == 8'd0);
        return {8'(m_addr), 8'(m_note), en, m_mode != M_IDLE, m_mode == M_SNZ, dn};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(start, stop, snooze);
        cyc++;
        #1;
        start = 1'b0; stop = 1'b0; snooze = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
    endtask

    task automatic load_song();
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'd0;
        rom_mem[0] = 8'd25;
        rom_mem[1] = 8'd24;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (obs !== 20'h0) begin n_fail++; $display("FAIL reset_values got=%h exp=%h", obs, 20'h0); end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        repeat (4) begin
            tick();
            n_chk++;
            if (obs !== model_out()) begin n_fail++; $display("FAIL pre_reset_model got=%h exp=%h", obs, model_out()); end
        end
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (obs !== 20'h0) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, 20'h0); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_first_note();
        cyc = 0;
        start = 1'b1;
        repeat (12) begin
            tick();
            n_chk++;
            if (obs !== model_out()) begin n_fail++; $display("FAIL first_note_model cyc=%0d got=%h exp=%h", cyc, obs, model_out()); end
            if (cyc == 1) begin
                n_chk++;
                if (rom_addr !== 8'd0 || playing !== 1'b1) begin n_fail++; $display("FAIL fetch0 addr=%0d playing=%b exp 0/1", rom_addr, playing); end
            end
            if (cyc >= 3 && cyc <= 6) begin
                n_chk++;
                if (note_en !== 1'b1 || note_out !== 8'd25) begin n_fail++; $display("FAIL note0 cyc=%0d en=%b note=%0d exp 1/25", cyc, note_en, note_out); end
            end
            if (cyc == 7 || cyc == 8) begin
                n_chk++;
                if (note_en !== 1'b0) begin n_fail++; $display("FAIL gap cyc=%0d en=%b exp 0", cyc, note_en); end
            end
            if (cyc == 9) begin
                n_chk++;
                if (rom_addr !== 8'd1) begin n_fail++; $display("FAIL addr1 got=%0d exp=1", rom_addr); end
            end
            if (cyc >= 11) begin
                n_chk++;
                if (note_out !== 8'd24) begin n_fail++; $display("FAIL note1 cyc=%0d got=%0d exp=24", cyc, note_out); end
            end
        end
    endtask

    task automatic test_end_of_song();
        int done_cnt = 0, done_cyc = -1, loud = 0;
        repeat (25) begin
            tick();
            n_chk++;
            if (obs !== model_out()) begin n_fail++; $display("FAIL eos_model cyc=%0d got=%h exp=%h", cyc, obs, model_out()); end
            if (song_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (cyc >= 19 && cyc <= 34 && note_en !== 1'b0) loud++;
            if (cyc == 35) begin
                n_chk++;
                if (rom_addr !== 8'd0 || playing !== 1'b1) begin n_fail++; $display("FAIL loop_addr got=%0d exp=0", rom_addr); end
            end
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != 18) begin n_fail++; $display("FAIL song_done count=%0d at=%0d exp 1 at 18", done_cnt, done_cyc); end
        n_chk++;
        if (loud != 0) begin n_fail++; $display("FAIL pause_silent loud=%0d exp=0", loud); end
        n_chk++;
        if (note_out !== 8'd25 || note_en !== 1'b1) begin n_fail++; $display("FAIL replay note=%0d en=%b exp 25/1", note_out, note_en); end
    endtask

    task automatic test_snooze();
        snooze = 1'b1;
        repeat (SN * NC) begin
            tick();
            n_chk++;
            if (obs !== model_out()) begin n_fail++; $display("FAIL snooze_model cyc=%0d got=%h exp=%h", cyc, obs, model_out()); end
            n_chk++;
            if (snoozing !== 1'b1 || note_en !== 1'b0) begin n_fail++; $display("FAIL snoozing cyc=%0d snz=%b en=%b exp 1/0", cyc, snoozing, note_en); end
        end
        tick();
        n_chk++;
        if (snoozing !== 1'b0 || playing !== 1'b1 || rom_addr !== 8'd0) begin
            n_fail++; $display("FAIL snooze_exit snz=%b play=%b addr=%0d exp 0/1/0", snoozing, playing, rom_addr);
        end
        go_idle();
    endtask

    task automatic test_stop_priority();
        start = 1'b1;
        repeat (3) tick();
        stop = 1'b1; snooze = 1'b1;
        tick();
        n_chk++;
        if ({playing, snoozing, note_en, rom_addr, note_out} !== 19'h0) begin
            n_fail++; $display("FAIL stop_prio play=%b snz=%b en=%b addr=%0d note=%0d exp all 0", playing, snoozing, note_en, rom_addr, note_out);
        end
        snooze = 1'b1;
        repeat (5) begin
            tick();
            n_chk++;
            if (obs !== model_out() || playing !== 1'b0 || snoozing !== 1'b0) begin
                n_fail++; $display("FAIL idle_snooze cyc=%0d got=%h exp=%h", cyc, obs, model_out());
            end
        end
    endtask

    task automatic test_addr_wrap();
        int prev = 0;
        bit saw = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(1 + (i % 200));
        start = 1'b1;
        repeat (256 * NC + 12) begin
            tick();
            n_chk++;
            if (obs !== model_out()) begin n_fail++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", cyc, obs, model_out()); end
            if (prev == 255 && rom_addr === 8'd0 && playing === 1'b1) saw = 1'b1;
            prev = int'(rom_addr);
        end
        n_chk++;
        if (saw !== 1'b1) begin n_fail++; $display("FAIL addr_wrap seen=%b exp=1", saw); end
        go_idle();
    endtask

    task automatic test_repeat_limit();
        bit exp_play;
        exp_play = LIMIT ? 1'b0 : 1'b1;
        load_song();
        cyc = 0;
        start = 1'b1;
        repeat (75) begin
            tick();
            n_chk++;
            if (obs !== model_out()) begin n_fail++; $display("FAIL repeat_model cyc=%0d got=%h exp=%h", cyc, obs, model_out()); end
            if (cyc == 52) begin
                n_chk++;
                if (song_done !== 1'b1) begin n_fail++; $display("FAIL second_done got=%b exp=1", song_done); end
            end
            if (cyc == 69) begin
                n_chk++;
                if (playing !== exp_play) begin n_fail++; $display("FAIL repeat_end playing=%b exp=%b", playing, exp_play); end
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) rom_mem[i] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
        for (int k = 0; k < 2000; k++) begin
            start  = ($urandom_range(0, 39) == 0);
            stop   = ($urandom_range(0, 299) == 0);
            snooze = ($urandom_range(0, 249) == 0);
            tick();
            n_chk++;
            if (obs !== model_out()) begin n_fail++; $display("FAIL random_model k=%0d got=%h exp=%h", k, obs, model_out()); end
        end
        go_idle();
    endtask

    initial begin
        load_song();
        test_reset();
        test_first_note();
        test_end_of_song();
        test_snooze();
        test_stop_priority();
        test_addr_wrap();
        test_repeat_limit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
